// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, synchronous-read memory between the instruction
// fetch requester and the data (load/store) requester. At most one access is
// issued per cycle. Read data comes back one cycle after the grant, tagged to
// its owner. Data normally wins. A streak counter bounds how many data grants
// can pass a waiting fetch before the fetch is forced through.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   fetch_req/addr/kill     fetch request, word address, redirect kill
//   fetch_gnt               fetch accepted this cycle
//   fetch_rvalid/rdata      fetch response, one cycle after the grant
//   data_req/addr/wdata/wbe data request; wbe==0 means load
//   data_gnt                data accepted; a store completes this cycle
//   data_rvalid/rdata       load response, one cycle after the grant
//   mem_en/addr/din/we      memory port drive
//   mem_dout                memory read data, valid the cycle after a read
module mem_port_arbiter #(
  parameter int ADDR_W          = 14,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_kill,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,

  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wbe,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_dout
);

  // The counter must be able to hold MAX_DATA_STREAK; keep at least one bit
  // so the MAX_DATA_STREAK==0 configuration still elaborates cleanly.
  localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    RSP_FETCH,
    RSP_DATA
  } rsp_state_t;

  rsp_state_t          state;
  rsp_state_t          state_next;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_next;
  logic                force_fetch;
  logic                fetch_win;
  logic                data_win;

  // Arbitration. Data wins unless a waiting fetch has already been passed
  // MAX_DATA_STREAK times. Both grants are held low during reset so the
  // pipeline sees a quiet port even before the state has been cleared.
  always_comb begin
    force_fetch = fetch_req && (streak == STREAK_MAX);
    data_win    = rst_n && data_req && !force_fetch;
    fetch_win   = rst_n && fetch_req && !data_win;
  end

  assign fetch_gnt = fetch_win;
  assign data_gnt  = data_win;

  // Memory port drive. Address and write data follow the winner; the write
  // enables are only ever non-zero for a data grant, so a fetch or an idle
  // cycle can never corrupt memory.
  always_comb begin
    mem_en   = fetch_win | data_win;
    mem_addr = data_win ? data_addr : fetch_addr;
    mem_din  = data_wdata;
    mem_we   = data_win ? data_wbe : 4'b0000;
  end

  // Streak counter: counts data grants that overtook a waiting fetch. It
  // restarts whenever the fetch side is served or stops asking, and holds at
  // its ceiling (fetch is forced on that cycle anyway).
  always_comb begin
    streak_next = streak;
    if (!fetch_req || fetch_win) begin
      streak_next = '0;
    end else if (data_win && (streak != STREAK_MAX)) begin
      streak_next = streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else begin
      streak <= streak_next;
    end
  end

  // Response FSM state register. The state for the response cycle is decided
  // entirely by what was granted in the previous cycle, so back-to-back reads
  // chain directly from one owner to the other with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and response outputs. A fetch killed in its grant cycle never
  // becomes a response; a kill in the response cycle just hides the valid.
  // Loads are never affected by fetch_kill. Valids are gated by rst_n so an
  // in-flight read is dropped as soon as reset is seen.
  always_comb begin
    state_next   = IDLE;
    fetch_rvalid = 1'b0;
    data_rvalid  = 1'b0;

    if (fetch_win && !fetch_kill) begin
      state_next = RSP_FETCH;
    end else if (data_win && (data_wbe == 4'b0000)) begin
      state_next = RSP_DATA;
    end

    if (rst_n) begin
      fetch_rvalid = (state == RSP_FETCH) && !fetch_kill;
      data_rvalid  = (state == RSP_DATA);
    end
  end

  assign fetch_rdata = mem_dout;
  assign data_rdata  = mem_dout;

endmodule
